// File: rtl/serial_word_adder_if.sv
// Handshake and data bundle for serial_word_adder: operand request side and result side.
// The producer/consumer drives through master; the adder itself uses slave.
interface serial_word_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             ovf_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, sub, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, ovf_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, sub, out_ready,
        output in_ready, out_valid, sum_out, cout_out, ovf_out, busy
    );
endinterface

// File: rtl/serial_word_adder.sv
// Bit-serial add/subtract of two parallel words through one full-adder cell, LSB first,
// with the sum reassembled into a parallel result carrying carry-out and signed overflow.
module serial_word_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    serial_word_adder_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             beff_msb_q, beff_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             carry_next;
    logic [WIDTH-1:0] b_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_msb_q    <= 1'b0;
            beff_msb_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_msb_q    <= a_msb_d;
            beff_msb_q <= beff_msb_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_msb_d    = a_msb_q;
        beff_msb_d = beff_msb_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;

        s_bit      = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
        b_eff      = bus.sub ? ~bus.b_in : bus.b_in;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d        = bus.a_in;
                    b_d        = b_eff;
                    carry_d    = bus.sub;
                    cnt_d      = '0;
                    a_msb_d    = bus.a_in[WIDTH-1];
                    beff_msb_d = b_eff[WIDTH-1];
                    state_d    = StShift;
                end
            end
            StShift: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = carry_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    ovf_d   = (a_msb_q == beff_msb_q) && (s_bit != a_msb_q);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sum_out   = sum_q;
    assign bus.cout_out  = cout_q;
    assign bus.ovf_out   = ovf_q;
endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: directed vectors, backpressure, mid-operation reset and
// randomized back-to-back traffic compared against an arithmetic reference.
module tb_serial_word_adder;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    int           accept_cyc;
    int           prev_accept;

    serial_word_adder_if #(.WIDTH(W)) bus ();

    serial_word_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] sm, output logic c, output logic o);
        longint ua, ub, sa, sb, r, one;
        one = 1;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[W-1] ? ua - (one << W) : ua;
        sb  = b[W-1] ? ub - (one << W) : ub;
        if (s) begin
            r  = sa - sb;
            c  = (ua >= ub);
            sm = W'(ua - ub);
        end else begin
            r  = sa + sb;
            c  = ((ua + ub) >= (one << W));
            sm = W'(ua + ub);
        end
        o = (r > (one << (W - 1)) - 1) || (r < -(one << (W - 1)));
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        model(a, b, s, exp_sum, exp_cout, exp_ovf);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
        tick();
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
        // Operands must have been captured at the accept edge only.
        bus.a_in     = W'($urandom);
        bus.b_in     = W'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic finish_op(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
        check({tag, "_sum"}, 64'(bus.sum_out), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.cout_out), 64'(exp_cout));
        check({tag, "_ovf"}, 64'(bus.ovf_out), 64'(exp_ovf));
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        start_op(a, b, s);
        finish_op(tag);
        handoff(tag);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout, held_ovf;
        int           seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", 64'(bus.sum_out), 64'd0);
        check("rst_flags", {62'd0, bus.cout_out, bus.ovf_out}, 64'd0);

        // Directed vectors; first one also probes busy during SHIFT.
        start_op(8'h5A, 8'h33, 1'b0);
        check("shift_busy", 64'(bus.busy), 64'd1);
        check("shift_in_ready", 64'(bus.in_ready), 64'd0);
        check("exp_5a33", 64'(exp_sum), 64'h8D);
        finish_op("add_5a_33");
        handoff("add_5a_33");
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_00_00", 8'h00, 8'h00, 1'b0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);

        // Backpressure: result must hold while new operands are offered.
        start_op(8'h7F, 8'h01, 1'b0);
        finish_op("bp");
        held_sum  = bus.sum_out;
        held_cout = bus.cout_out;
        held_ovf  = bus.ovf_out;
        for (int i = 0; i < 5; i++) begin
            bus.a_in     = W'($urandom);
            bus.in_valid = 1'b1;
            tick();
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold", {bus.sum_out, bus.cout_out, bus.ovf_out},
                  {held_sum, held_cout, held_ovf});
        end
        bus.in_valid = 1'b0;
        handoff("bp");
        run_op("after_bp", 8'h21, 8'h42, 1'b0);

        // Reset on the third SHIFT cycle discards the operation.
        start_op(8'h5A, 8'h33, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_outs", {bus.out_valid, bus.sum_out, bus.cout_out, bus.ovf_out}, 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        run_op("post_rst", 8'h01, 8'h02, 1'b0);

        // Back-to-back random traffic with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            if (i > 0) check("b2b_spacing", 64'(accept_cyc - prev_accept), 64'(W + 2));
            prev_accept = accept_cyc;
            finish_op("b2b");
        end
        tick();
        bus.out_ready = 1'b0;
        check("b2b_idle", 64'(bus.in_ready), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
